// File: rtl/mod_exp_ctrl_if.sv
// Bundle of the command/status side and the modulo-unit side of mod_exp_ctrl.
// The controller uses the slave view; whoever issues requests and models the
// modulo unit uses the master view.
interface mod_exp_ctrl_if #(
  parameter int WIDTH = 32
);
  // command / status
  logic             start;
  logic [WIDTH-1:0] base_in;
  logic [WIDTH-1:0] exp_in;
  logic [WIDTH-1:0] mod_in;
  logic             busy;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] result;

  // modulo unit request / response
  logic             mod_ena;
  logic [WIDTH-1:0] mod_a;
  logic [WIDTH-1:0] mod_b;
  logic             mod_write;
  logic [WIDTH-1:0] mod_res;

  modport master (
    output start, base_in, exp_in, mod_in, mod_write, mod_res,
    input  busy, done, err, result, mod_ena, mod_a, mod_b
  );

  modport slave (
    input  start, base_in, exp_in, mod_in, mod_write, mod_res,
    output busy, done, err, result, mod_ena, mod_a, mod_b
  );
endinterface

// File: rtl/mod_exp_ctrl.sv
// Modular exponentiation sequencer: result = base^exp mod n using right-to-left
// square-and-multiply. Every reduction is delegated to an external sequential
// modulo unit; this block only forms products and sequences the requests.
module mod_exp_ctrl #(
  parameter int WIDTH = 32
) (
  input logic           clock,
  input logic           reset,
  mod_exp_ctrl_if.slave bus
);

  localparam int HALF = WIDTH / 2;
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_ISSUE  = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_STEP   = 3'd4;
  localparam logic [2:0] ST_FINISH = 3'd5;
  localparam logic [2:0] ST_FAIL   = 3'd6;

  localparam logic [1:0] OP_BASE = 2'd0;
  localparam logic [1:0] OP_MUL  = 2'd1;
  localparam logic [1:0] OP_SQR  = 2'd2;

  logic [2:0]       state_reg,   state_next;
  logic [1:0]       op_reg,      op_next;
  logic [WIDTH-1:0] b_reg,       b_next;
  logic [WIDTH-1:0] e_reg,       e_next;
  logic [WIDTH-1:0] n_reg,       n_next;
  logic [WIDTH-1:0] acc_reg,     acc_next;
  logic [WIDTH-1:0] result_reg,  result_next;
  logic [WIDTH-1:0] mod_a_reg,   mod_a_next;
  logic             busy_reg,    busy_next;
  logic             done_reg,    done_next;
  logic             err_reg,     err_next;
  logic             mod_ena_reg, mod_ena_next;

  // Operands are already reduced below n < 2^(WIDTH/2), so these products
  // never overflow WIDTH bits.
  logic [WIDTH-1:0] prod_ab;
  logic [WIDTH-1:0] prod_bb;
  logic [WIDTH-1:0] e_shift;
  logic             n_too_big;

  assign prod_ab   = acc_reg * b_reg;
  assign prod_bb   = b_reg * b_reg;
  assign e_shift   = e_reg >> 1;
  assign n_too_big = |n_reg[WIDTH-1:HALF];

  assign bus.busy    = busy_reg;
  assign bus.done    = done_reg;
  assign bus.err     = err_reg;
  assign bus.result  = result_reg;
  assign bus.mod_ena = mod_ena_reg;
  assign bus.mod_a   = mod_a_reg;
  assign bus.mod_b   = n_reg;

  // Next-state and datapath decisions for the sequencer.
  always_comb begin
    state_next   = state_reg;
    op_next      = op_reg;
    b_next       = b_reg;
    e_next       = e_reg;
    n_next       = n_reg;
    acc_next     = acc_reg;
    result_next  = result_reg;
    mod_a_next   = mod_a_reg;
    busy_next    = busy_reg;
    done_next    = 1'b0;
    err_next     = 1'b0;
    mod_ena_next = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        // A start coinciding with the done/err pulse is not a new request.
        if (bus.start && !done_reg && !err_reg) begin
          b_next     = bus.base_in;
          e_next     = bus.exp_in;
          n_next     = bus.mod_in;
          busy_next  = 1'b1;
          state_next = ST_LOAD;
        end
      end

      ST_LOAD: begin
        if (n_reg == '0 || n_too_big) begin
          state_next = ST_FAIL;
        end else if (n_reg == ONE) begin
          acc_next   = '0;
          state_next = ST_FINISH;
        end else if (e_reg == '0) begin
          acc_next   = ONE;
          state_next = ST_FINISH;
        end else begin
          // Reduce the raw base first; everything after works on residues.
          acc_next     = ONE;
          op_next      = OP_BASE;
          mod_a_next   = b_reg;
          mod_ena_next = 1'b1;
          state_next   = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        state_next = ST_WAIT;
      end

      ST_WAIT: begin
        if (bus.mod_write) begin
          if (op_reg == OP_MUL) begin
            acc_next = bus.mod_res;
          end else begin
            b_next = bus.mod_res;
          end
          state_next = ST_STEP;
        end
      end

      ST_STEP: begin
        if (op_reg != OP_MUL) begin
          if (e_reg == '0) begin
            state_next = ST_FINISH;
          end else if (e_reg[0]) begin
            op_next      = OP_MUL;
            mod_a_next   = prod_ab;
            mod_ena_next = 1'b1;
            state_next   = ST_ISSUE;
          end else begin
            e_next       = e_shift;
            op_next      = OP_SQR;
            mod_a_next   = prod_bb;
            mod_ena_next = 1'b1;
            state_next   = ST_ISSUE;
          end
        end else begin
          // Consume the bit just multiplied in; skip the useless last square.
          e_next = e_shift;
          if (e_shift == '0) begin
            state_next = ST_FINISH;
          end else begin
            op_next      = OP_SQR;
            mod_a_next   = prod_bb;
            mod_ena_next = 1'b1;
            state_next   = ST_ISSUE;
          end
        end
      end

      ST_FINISH: begin
        result_next = acc_reg;
        done_next   = 1'b1;
        busy_next   = 1'b0;
        state_next  = ST_IDLE;
      end

      ST_FAIL: begin
        err_next   = 1'b1;
        busy_next  = 1'b0;
        state_next = ST_IDLE;
      end

      default: begin
        busy_next  = 1'b0;
        state_next = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg   <= ST_IDLE;
      op_reg      <= OP_BASE;
      b_reg       <= '0;
      e_reg       <= '0;
      n_reg       <= '0;
      acc_reg     <= '0;
      result_reg  <= '0;
      mod_a_reg   <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
      mod_ena_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      op_reg      <= op_next;
      b_reg       <= b_next;
      e_reg       <= e_next;
      n_reg       <= n_next;
      acc_reg     <= acc_next;
      result_reg  <= result_next;
      mod_a_reg   <= mod_a_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      err_reg     <= err_next;
      mod_ena_reg <= mod_ena_next;
    end
  end

endmodule

// File: doc/mod_exp_ctrl.md
# mod_exp_ctrl

Sequencer for modular exponentiation. It computes result = base^exp mod n using right-to-left binary square-and-multiply. It sits directly upstream of the sequential modulo unit (mod_operation) and feeds it every reduction it needs. It drives that unit's enable and operands, waits for its write strobe, and consumes each remainder it produces.

## Interface
- WIDTH, 32: datapath width of all operand, result and mod-unit buses.
- clock  in  1  single system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clock.
- start  in  1  request; sampled only in IDLE.
- base_in  in  WIDTH  base; captured on an accepted start.
- exp_in  in  WIDTH  exponent; captured on an accepted start.
- mod_in  in  WIDTH  modulus n; captured on an accepted start.
- busy  out  1  high from the cycle after an accepted start until done/err.
- done  out  1  one-cycle pulse; result valid.
- err  out  1  one-cycle pulse; modulus rejected.
- result  out  WIDTH  final value; held until the next accepted start.
- mod_ena  out  1  one-cycle request to the mod unit.
- mod_a  out  WIDTH  dividend to the mod unit.
- mod_b  out  WIDTH  divisor to the mod unit; always equals captured n.
- mod_write  in  1  mod-unit result-valid strobe.
- mod_res  in  WIDTH  mod-unit remainder.

## Operation
- Internal registers:
  - b_r: running base.
  - e_r: remaining exponent.
  - n_r: modulus.
  - acc_r: accumulator.
  - op_r: pending operation, one of BASE, MUL or SQR.
- Product width rule: the mod unit is WIDTH-bit only, so n must be below 2^(WIDTH/2). Products of two reduced operands are then computed in WIDTH bits with no overflow.
- State machine: IDLE, LOAD, ISSUE, WAIT, STEP, FINISH, FAIL.
- IDLE
  - On start=1: capture inputs, set busy, go to LOAD.
  - start=0: stay in IDLE.
- LOAD
  - If n==0 or n>=2^(WIDTH/2): go to FAIL.
  - Else if n==1: acc_r=0, go to FINISH.
  - Else if exp==0: acc_r=1, go to FINISH.
  - Else: acc_r=1, op_r=BASE, mod_a=base, go to ISSUE.
- ISSUE
  - mod_ena=1 for exactly this cycle; go to WAIT.
  - mod_a and mod_b stay stable from ISSUE until mod_write is seen.
- WAIT
  - Hold mod_ena=0.
  - On mod_write=1, latch mod_res by op_r:
    - BASE or SQR: b_r=mod_res.
    - MUL: acc_r=mod_res.
  - Then go to STEP.
  - mod_write is ignored in every state except WAIT.
- STEP
  - After BASE or SQR:
    - If e_r==0: go to FINISH.
    - Else if e_r[0]==1: op_r=MUL, mod_a=acc_r*b_r, go to ISSUE.
    - Else: e_r=e_r>>1, op_r=SQR, mod_a=b_r*b_r, go to ISSUE.
  - After MUL:
    - e_r=e_r>>1.
    - If the new e_r==0: go to FINISH; the final squaring is skipped.
    - Else: op_r=SQR, mod_a=b_r*b_r, go to ISSUE.
- FINISH: result=acc_r, done=1, busy=0, go to IDLE.
- FAIL: err=1, busy=0, result unchanged, go to IDLE.
- Number of mod_ena pulses per run: 1 + popcount(exp) + (bit-length(exp) − 1).

## Timing
- Reset values: busy=0, done=0, err=0, result=0, mod_ena=0, mod_a=0, mod_b=0; state=IDLE.
- Reset mid-operation: the same values apply on the next edge. Any in-flight mod_write is ignored afterwards, and no done is produced.
- start asserted while busy is ignored. A start in the same cycle done pulses is also ignored; the block only accepts in IDLE.
- Latency, with cycle 0 = start sampled:
  - busy rises at cycle 1.
  - Trivial cases (n==1, exp==0) pulse done at cycle 3.
  - Bad modulus pulses err at cycle 3.
  - General case: 3 + Σ(2 + D_k) cycles, where D_k is the mod-unit latency of operation k from mod_ena to mod_write.
- mod_ena is never asserted while a previous request is outstanding.
- done and err are mutually exclusive single-cycle pulses.
- busy falls in the same cycle as done or err.

## Test plan
- base=4, exp=13, n=497, with the real mod_operation attached:
  - done with result=445.
  - exactly 7 mod_ena pulses.
  - mod_b=497 throughout.
- base=100, exp=2, n=7: the BASE reduction yields 2, then done with result=4. Run it again with exp=1: result=2, and no SQR is issued.
- Trivial and error cases, each checked for zero mod_ena pulses:
  - base=3, exp=0, n=7: result=1, done at cycle 3.
  - base=10, exp=5, n=1: result=0.
  - n=0: err at cycle 3, result unchanged.
  - n=65536: err at cycle 3, result unchanged.
- Behavioural mod model with a random 1–40 cycle delay, 200 random base/exp values with n<65536:
  - result matches a reference model.
  - mod_a is stable while each request is outstanding.
  - start pulses injected while busy are ignored.
- Reset (reset=0) during the WAIT state of 4^13 mod 497:
  - all outputs return to 0.
  - a late mod_write is ignored.
  - a following 5^3 mod 13 run gives result=8.
